// File: rtl/memory_access.sv
// Memory stage: issues load/store transactions on a req/ack data port, handles
// lane selection and extension, and registers the MEM->WB and CP0 forwarding outputs.
module memory_access #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_valid,
  input  logic [3:0]                ex_mem_op,
  input  logic [DATA_WIDTH-1:0]     ex_res,
  input  logic [DATA_WIDTH-1:0]     ex_store_data,
  input  logic                      ex_wb_reg,
  input  logic [REG_ADDR_WIDTH-1:0] ex_wb_addr,
  input  logic                      ex_wb_cp0,
  input  logic [4:0]                ex_cp0_addr,
  input  logic [DATA_WIDTH-1:0]     ex_cp0_data,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [ADDR_WIDTH-1:0]     dmem_addr,
  output logic [3:0]                dmem_be,
  output logic [DATA_WIDTH-1:0]     dmem_wdata,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata,
  input  logic                      dmem_ack,
  output logic                      mem_stall,
  output logic                      addr_err,
  output logic                      wb_valid,
  output logic                      wb_reg,
  output logic [REG_ADDR_WIDTH-1:0] wb_addr,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      mem_wb_cp0,
  output logic [4:0]                mem_cp0_write_addr,
  output logic [DATA_WIDTH-1:0]     mem_cp0_write
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e state, state_next;

  logic                      is_mem, misaligned;
  logic                      accept_none, accept_mem, accept_misal;
  logic [3:0]                be_next;
  logic [DATA_WIDTH-1:0]     wdata_next;
  logic [DATA_WIDTH-1:0]     load_data;
  logic [7:0]                load_byte;
  logic [15:0]               load_half;

  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [3:0]                op_q;
  logic [1:0]                off_q;
  logic [3:0]                be_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic                      we_q;
  logic                      wb_reg_q;
  logic [REG_ADDR_WIDTH-1:0] wb_addr_q;

  // Operation decode, alignment check and store lane steering from the ex_* inputs.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    is_mem     = 1'b0;
    misaligned = 1'b0;
    be_next    = 4'b1111;
    wdata_next = ex_store_data;
    case (ex_mem_op)
      OP_LB, OP_LBU: is_mem = 1'b1;
      OP_LH, OP_LHU: begin
        is_mem     = 1'b1;
        misaligned = ex_res[0];
      end
      OP_LW: begin
        is_mem     = 1'b1;
        misaligned = (ex_res[1:0] != 2'b00);
      end
      OP_SB: begin
        is_mem     = 1'b1;
        be_next    = 4'b0001 << ex_res[1:0];
        wdata_next = {4{ex_store_data[7:0]}};
      end
      OP_SH: begin
        is_mem     = 1'b1;
        misaligned = ex_res[0];
        be_next    = ex_res[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{ex_store_data[15:0]}};
      end
      OP_SW: begin
        is_mem     = 1'b1;
        misaligned = (ex_res[1:0] != 2'b00);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next   = state;
    accept_none  = 1'b0;
    accept_mem   = 1'b0;
    accept_misal = 1'b0;
    case (state)
      IDLE: begin
        if (ex_valid) begin
          if (!is_mem) begin
            accept_none = 1'b1;
          end else if (misaligned) begin
            accept_misal = 1'b1;
          end else begin
            accept_mem = 1'b1;
            state_next = ACCESS;
          end
        end
      end
      ACCESS: if (dmem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Port outputs decode from registered state only, so an async reset drops req at once.
  always_comb begin
    mem_stall  = (state == ACCESS);
    dmem_req   = mem_stall;
    dmem_we    = mem_stall & we_q;
    dmem_addr  = mem_stall ? addr_q  : '0;
    dmem_be    = mem_stall ? be_q    : 4'b0000;
    dmem_wdata = mem_stall ? wdata_q : '0;
  end

  always_comb begin
    load_byte = dmem_rdata[8*off_q +: 8];
    load_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (op_q)
      OP_LB:   load_data = {{(DATA_WIDTH-8){load_byte[7]}}, load_byte};
      OP_LBU:  load_data = {{(DATA_WIDTH-8){1'b0}}, load_byte};
      OP_LH:   load_data = {{(DATA_WIDTH-16){load_half[15]}}, load_half};
      OP_LHU:  load_data = {{(DATA_WIDTH-16){1'b0}}, load_half};
      default: load_data = dmem_rdata;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q             <= '0;
      op_q               <= 4'd0;
      off_q              <= 2'b00;
      be_q               <= 4'b0000;
      wdata_q            <= '0;
      we_q               <= 1'b0;
      wb_reg_q           <= 1'b0;
      wb_addr_q          <= '0;
      addr_err           <= 1'b0;
      wb_valid           <= 1'b0;
      wb_reg             <= 1'b0;
      wb_addr            <= '0;
      wb_data            <= '0;
      mem_wb_cp0         <= 1'b0;
      mem_cp0_write_addr <= 5'd0;
      mem_cp0_write      <= '0;
    end else begin
      addr_err <= accept_misal;
      if (state == IDLE) begin
        if (accept_mem) begin
          addr_q     <= {ex_res[ADDR_WIDTH-1:2], 2'b00};
          op_q       <= ex_mem_op;
          off_q      <= ex_res[1:0];
          be_q       <= be_next;
          wdata_q    <= wdata_next;
          we_q       <= (ex_mem_op >= OP_SB);
          wb_reg_q   <= ex_wb_reg;
          wb_addr_q  <= ex_wb_addr;
          wb_valid   <= 1'b0;
          mem_wb_cp0 <= 1'b0;
        end else if (accept_none) begin
          wb_valid           <= 1'b1;
          wb_reg             <= ex_wb_reg;
          wb_addr            <= ex_wb_addr;
          wb_data            <= ex_res;
          mem_wb_cp0         <= ex_wb_cp0;
          mem_cp0_write_addr <= ex_cp0_addr;
          mem_cp0_write      <= ex_cp0_data;
        end else begin
          wb_valid   <= 1'b0;
          wb_reg     <= 1'b0;
          mem_wb_cp0 <= 1'b0;
        end
      end else if (dmem_ack) begin
        wb_valid <= 1'b1;
        wb_reg   <= we_q ? 1'b0 : wb_reg_q;
        wb_addr  <= wb_addr_q;
        if (!we_q) wb_data <= load_data;
      end
    end
  end

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
Memory stage controller sitting directly downstream of the execution stage. Consumes the execution result, the store operand and the writeback/CP0 control, and performs load/store transactions on the data-memory port with a req/ack handshake. Handles byte/half/word lane selection and sign/zero extension. Drives the registered MEM->WB outputs, including the mem_wb_cp0 forwarding triple that the execution stage reads back.

Parameters:
DATA_WIDTH, 32, datapath width; byte-lane logic is fixed at 4 lanes.
ADDR_WIDTH, 16, byte-address width of the data-memory port.
REG_ADDR_WIDTH, 5, GPR index width.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst_n  in  1  asynchronous active-low reset.
ex_valid  in  1  execution stage presents an instruction this cycle.
ex_mem_op  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; other values are treated as NONE.
ex_res  in  DATA_WIDTH  execution result; byte address for memory ops.
ex_store_data  in  DATA_WIDTH  rt value for stores.
ex_wb_reg  in  1  instruction writes a GPR.
ex_wb_addr  in  REG_ADDR_WIDTH  destination GPR.
ex_wb_cp0  in  1  instruction writes CP0.
ex_cp0_addr  in  5  CP0 destination.
ex_cp0_data  in  DATA_WIDTH  CP0 write data.
dmem_req  out  1  memory request.
dmem_we  out  1  1 = store.
dmem_addr  out  ADDR_WIDTH  word-aligned byte address; low 2 bits are 0.
dmem_be  out  4  byte enables; bit i = byte lane i (little-endian).
dmem_wdata  out  DATA_WIDTH  lane-replicated store data.
dmem_rdata  in  DATA_WIDTH  load data, valid with ack.
dmem_ack  in  1  transaction complete.
mem_stall  out  1  upstream must hold its current instruction.
addr_err  out  1  one-cycle misaligned-address pulse for CP0.
wb_valid  out  1  writeback stage entry valid.
wb_reg  out  1  GPR write enable to writeback.
wb_addr  out  REG_ADDR_WIDTH  GPR index to writeback.
wb_data  out  DATA_WIDTH  GPR data to writeback.
mem_wb_cp0  out  1  registered CP0 write enable; also the forwarding source.
mem_cp0_write_addr  out  5  registered CP0 address.
mem_cp0_write  out  DATA_WIDTH  registered CP0 data.

Behaviour:
- Reset: state IDLE; every output is 0, including dmem_req. This also applies mid-transaction: req drops immediately and the pending instruction is discarded.
- FSM has two states, IDLE and ACCESS.
- IDLE accepts when ex_valid=1.
  - mem_op NONE: wb_*, mem_cp0_* and mem_wb_cp0 are registered from ex_* on the next edge (latency 1), with wb_data=ex_res. State stays IDLE.
  - Memory op: misalignment is checked first. LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, is misaligned.
    - Misaligned: no request is issued. addr_err=1 for exactly one cycle and wb_valid=0 on the next edge.
    - Aligned: address, op, lane offset, be, wdata and wb_addr are latched, and state goes to ACCESS.
- IDLE with ex_valid=0: next cycle wb_valid=0, wb_reg=0, mem_wb_cp0=0.
- ACCESS:
  - dmem_req=1 with all dmem_* driven from latched registers and held stable until ack.
  - mem_stall=1 for every ACCESS cycle, including the ack cycle. ex_* inputs are ignored.
  - On dmem_ack=1, state returns to IDLE. On that edge wb_valid=1 is registered.
    - Loads: wb_reg=latched ex_wb_reg, wb_data=extracted lane.
    - Stores: wb_reg=0.
  - mem_wb_cp0=0 for all memory ops.
- mem_stall=0 in IDLE, so accept-to-writeback latency is 2 + wait cycles; the minimum is ack in the first ACCESS cycle.
- dmem_ack in IDLE is ignored.
- Store lanes:
  - SB: be=4'b0001<<addr[1:0], wdata={4{data[7:0]}}.
  - SH: be=addr[1]?4'b1100:4'b0011, wdata={2{data[15:0]}}.
  - SW: be=4'b1111, wdata=data.
- Loads: dmem_be=4'b1111; the result is taken from the lane selected by the latched addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LW passes rdata unchanged.
- wb_* and mem_cp0_* hold their values while in ACCESS, except wb_valid/mem_wb_cp0, which are 0 after the first ACCESS edge.

Test Plan:
- NONE op: ex_valid=1, ex_res=32'h1234_5678, wb_reg=1, wb_addr=3 -> next cycle wb_valid=1, wb_data=32'h1234_5678, wb_addr=3, mem_stall never 1.
- LB at 0x0003, rdata=32'h80FF_1122, ack 2 cycles after req -> req held 3 cycles with dmem_addr=0x0000, mem_stall=1 for those 3 cycles, then wb_data=32'hFFFF_FF80; LBU gives 32'h0000_0080.
- SH at 0x0006, store_data=32'hAAAA_BEEF -> dmem_we=1, dmem_addr=0x0004, be=4'b1100, wdata=32'hBEEF_BEEF; after ack wb_valid=1, wb_reg=0.
- LW at 0x0002 -> no dmem_req, addr_err one-cycle pulse, wb_valid=0.
- mtc0 (ex_wb_cp0=1, addr 12, data 32'h0000_FF01) -> next cycle mem_wb_cp0=1, mem_cp0_write_addr=12, mem_cp0_write=32'h0000_FF01.
- rst_n low during ACCESS, with ack arriving after release -> dmem_req drops asynchronously, outputs are 0, and the stray ack produces no wb_valid.
